// File: rtl/fetch_pkg.sv
// Shared constants, PC step helper and queue entry layout for the fetch stage.
package fetch_pkg;

  localparam int          DEF_ADDR_WIDTH = 32;
  localparam int          DEF_DATA_WIDTH = 32;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;

  // Byte distance between consecutive instructions.
  function automatic int pc_step(input int data_width);
    return data_width / 8;
  endfunction

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {instr, pc} entries with flush; DEPTH must be a power of two
// so the read/write pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk) begin
    if (!reset || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only; a flushed write is simply never made visible.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction fetch with single-outstanding memory requests and a decoupling queue.
// Optional FETCH_PERF_COUNTERS_EN adds saturating stallCount / redirectCount outputs.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hazard,
  input  logic                  outputBrachControlInput,
  input  logic [ADDR_WIDTH-1:0] pcBranchInput,
  input  logic                  jumpInput,
  input  logic [ADDR_WIDTH-1:0] pcJumpInput,
  output logic                  imemReq,
  output logic [ADDR_WIDTH-1:0] imemAddr,
  input  logic                  imemValid,
  input  logic [DATA_WIDTH-1:0] imemData,
  output logic                  validOutput,
  output logic [DATA_WIDTH-1:0] instructionOutput,
  output logic [ADDR_WIDTH-1:0] pcOutput,
  output logic [ADDR_WIDTH-1:0] pc4Output
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]           stallCount,
  output logic [31:0]           redirectCount
`endif
);

  localparam int                    CW   = $clog2(DEPTH) + 1;
  localparam int                    RW   = CW + 1;
  localparam int                    EW   = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(pc_step(DATA_WIDTH));

  logic [ADDR_WIDTH-1:0] r_fetchPc;
  logic [ADDR_WIDTH-1:0] r_reqPc;
  logic                  r_outstanding;
  logic                  r_drop;

  logic                  w_redirect;
  logic [ADDR_WIDTH-1:0] w_target;
  logic                  w_valid;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic [RW-1:0]         w_reserved;
  logic [CW-1:0]         w_count;
  logic [EW-1:0]         w_head;

  // Reservation counts the entry landing this cycle plus any request still in
  // flight afterwards, so a response always finds a free slot.
  always_comb begin
    w_redirect = jumpInput | outputBrachControlInput;
    w_target   = jumpInput ? pcJumpInput : pcBranchInput;
    w_valid    = (w_count != '0);
    w_push     = r_outstanding & imemValid & ~r_drop & ~w_redirect;
    w_pop      = w_valid & ~hazard & ~w_redirect;
    w_reserved = {1'b0, w_count} + RW'(w_push) + RW'(r_outstanding & ~imemValid);
    w_issue    = reset & ~w_redirect & (~r_outstanding | imemValid)
               & (w_reserved < RW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetchPc     <= RESET_PC;
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      r_outstanding <= w_issue | (r_outstanding & ~imemValid);
      r_drop        <= r_outstanding & ~imemValid & (r_drop | w_redirect);
      if (w_redirect)   r_fetchPc <= w_target;
      else if (w_issue) r_fetchPc <= r_fetchPc + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) r_reqPc <= r_fetchPc;
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_data  ({imemData, r_reqPc}),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign imemReq           = w_issue;
  assign imemAddr          = r_fetchPc;
  assign validOutput       = w_valid;
  assign instructionOutput = w_valid ? w_head[EW-1:ADDR_WIDTH] : '0;
  assign pcOutput          = w_valid ? w_head[ADDR_WIDTH-1:0] : '0;
  assign pc4Output         = w_valid ? w_head[ADDR_WIDTH-1:0] + STEP : '0;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] r_stallCount;
  logic [31:0] r_redirectCount;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stallCount    <= '0;
      r_redirectCount <= '0;
    end else begin
      if (w_valid && hazard) r_stallCount    <= sat_inc(r_stallCount);
      if (w_redirect)        r_redirectCount <= sat_inc(r_redirectCount);
    end
  end

  assign stallCount    = r_stallCount;
  assign redirectCount = r_redirectCount;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: queue-based reference model, variable-latency memory,
// directed scenarios followed by randomized hazard/redirect traffic.
module tb_fetch_queue_stage;
  import fetch_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hazard = 1'b0;
  logic        br = 1'b0;
  logic        jp = 1'b0;
  logic [31:0] bt = '0;
  logic [31:0] jt = '0;
  logic        imemValid = 1'b0;
  logic [31:0] imemData = '0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        validOutput;
  logic [31:0] instructionOutput;
  logic [31:0] pcOutput;
  logic [31:0] pc4Output;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] stallCount;
  logic [31:0] redirectCount;
`endif

  always #5 clk = ~clk;

  fetch_queue_stage #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .RESET_PC   (RST_PC)
  ) dut (
`ifdef FETCH_PERF_COUNTERS_EN
    .stallCount              (stallCount),
    .redirectCount           (redirectCount),
`endif
    .clk                     (clk),
    .reset                   (reset),
    .hazard                  (hazard),
    .outputBrachControlInput (br),
    .pcBranchInput           (bt),
    .jumpInput               (jp),
    .pcJumpInput             (jt),
    .imemReq                 (imemReq),
    .imemAddr                (imemAddr),
    .imemValid               (imemValid),
    .imemData                (imemData),
    .validOutput             (validOutput),
    .instructionOutput       (instructionOutput),
    .pcOutput                (pcOutput),
    .pc4Output               (pc4Output)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Memory model: one pending response, delivered lat cycles after its request.
  bit          mem_pend = 1'b0;
  int          mem_due = 0;
  logic [31:0] mem_data = '0;
  int          lat_fixed = 1;
  bit          spur_en = 1'b0;

  // Reference model state.
  fetch_entry_t mq[$];
  logic [31:0]  m_fpc = RST_PC;
  logic [31:0]  m_reqpc = '0;
  bit           m_out = 1'b0;
  bit           m_drop = 1'b0;
  int           m_stall = 0;
  int           m_redir = 0;

  // Last sampled DUT outputs.
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc, s_pc4, s_stall, s_redir;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  task automatic cycle();
    bit           hit, redirect, pop, push, issue;
    logic [31:0]  target;
    int           reserved;
    fetch_entry_t e;
    hit       = mem_pend && (cyc == mem_due);
    imemValid = hit || (!mem_pend && spur_en && ($urandom_range(0, 9) == 0));
    imemData  = hit ? mem_data : $urandom();
    @(negedge clk);
    s_req = imemReq; s_addr = imemAddr; s_valid = validOutput;
    s_instr = instructionOutput; s_pc = pcOutput; s_pc4 = pc4Output;
`ifdef FETCH_PERF_COUNTERS_EN
    s_stall = stallCount; s_redir = redirectCount;
`else
    s_stall = '0; s_redir = '0;
`endif
    if (!reset) begin
      chk("reset_imemReq", {31'b0, s_req}, 32'd0);
      mq.delete();
      m_fpc = RST_PC; m_out = 1'b0; m_drop = 1'b0;
      m_stall = 0; m_redir = 0; mem_pend = 1'b0;
    end else begin
      redirect = jp || br;
      target   = jp ? jt : bt;
      pop      = (mq.size() != 0) && !hazard && !redirect;
      push     = imemValid && m_out && !m_drop && !redirect;
      reserved = mq.size() + int'(push) + int'(m_out && !imemValid);
      issue    = !redirect && (!m_out || imemValid) && (reserved < DEPTH);
      chk("imemReq", {31'b0, s_req}, {31'b0, issue});
      if (issue) chk("imemAddr", s_addr, m_fpc);
      chk("validOutput", {31'b0, s_valid}, {31'b0, (mq.size() != 0)});
      if (mq.size() != 0) begin
        chk("instructionOutput", s_instr, mq[0].instr);
        chk("pcOutput", s_pc, mq[0].pc);
        chk("pc4Output", s_pc4, mq[0].pc + 32'd4);
      end
`ifdef FETCH_PERF_COUNTERS_EN
      chk("stallCount", s_stall, m_stall);
      chk("redirectCount", s_redir, m_redir);
      if ((mq.size() != 0) && hazard) m_stall++;
      if (redirect) m_redir++;
`endif
      if (redirect) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          e.instr = imemData; e.pc = m_reqpc;
          mq.push_back(e);
        end
      end
      m_drop = m_out && !imemValid && (m_drop || redirect);
      if (issue) m_reqpc = m_fpc;
      m_out = issue || (m_out && !imemValid);
      m_fpc = redirect ? target : (issue ? m_fpc + 32'd4 : m_fpc);
      if (imemValid && mem_pend) mem_pend = 1'b0;
      if (s_req) begin
        mem_pend = 1'b1;
        mem_due  = cyc + ((lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4)));
        mem_data = $urandom();
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int          nreq, first_req, first_val, k, nv;
  bit          seen, found;
  logic [31:0] ra [3];
  logic [31:0] fpc, fpc4, prev_pc;

  initial begin
    #1;
    reset = 1'b0;
    repeat (3) cycle();
    chk("rst_valid", {31'b0, s_valid}, 32'd0);
    chk("rst_instr", s_instr, 32'd0);
    chk("rst_pc", s_pc, 32'd0);
    chk("rst_pc4", s_pc4, 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("rst_stall", s_stall, 32'd0);
    chk("rst_redir", s_redir, 32'd0);
`endif

    // Sequential fetch from RESET_PC with latency 1.
    reset = 1'b1; lat_fixed = 1;
    nreq = 0; seen = 1'b0; first_req = -1; first_val = -1;
    for (int i = 0; i < 3; i++) ra[i] = 32'hDEAD_BEEF;
    for (int i = 0; i < 20 && (nreq < 3 || !seen); i++) begin
      cycle();
      if (s_req && nreq < 3) begin
        if (nreq == 0) first_req = i;
        ra[nreq] = s_addr; nreq++;
      end
      if (s_valid && !seen) begin
        seen = 1'b1; first_val = i; fpc = s_pc; fpc4 = s_pc4;
      end
    end
    chk("t1_req0", ra[0], 32'h100);
    chk("t1_req1", ra[1], 32'h104);
    chk("t1_req2", ra[2], 32'h108);
    chk("t1_seen", {31'b0, seen}, 32'd1);
    chk("t1_head_pc", fpc, 32'h100);
    chk("t1_head_pc4", fpc4, 32'h104);
    chk("t1_latency", first_val - first_req, 32'd2);

    // Hazard holds the queue full; release drains in PC order.
    hazard = 1'b1;
    repeat (12) cycle();
    chk("t2_req_idle", {31'b0, s_req}, 32'd0);
    chk("t2_valid", {31'b0, s_valid}, 32'd1);
    chk("t2_model_depth", mq.size(), DEPTH);
    hazard = 1'b0;
    seen = 1'b0;
    cycle();
    prev_pc = s_pc;
    if (s_req) seen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t2_pop_order", s_pc - prev_pc, 32'd4);
      prev_pc = s_pc;
      if (s_req) seen = 1'b1;
    end
    chk("t2_issue_resumed", {31'b0, seen}, 32'd1);

    // Jump + branch together with a request in flight (L=3).
    lat_fixed = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (s_req) found = 1'b1;
    end
    chk("t3_req_found", {31'b0, found}, 32'd1);
    jp = 1'b1; jt = 32'h400; br = 1'b1; bt = 32'h200;
    cycle();
    jp = 1'b0; br = 1'b0;
    chk("t3_redir_noreq", {31'b0, s_req}, 32'd0);
    found = 1'b0; k = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(); k++;
      if (k == 1) chk("t3_flushed", {31'b0, s_valid}, 32'd0);
      if (s_req) found = 1'b1;
    end
    chk("t3_req_after_drop", k, 32'd2);
    chk("t3_req_addr", s_addr, 32'h400);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (s_valid) found = 1'b1;
    end
    chk("t3_head_pc", s_pc, 32'h400);
    chk("t3_head_pc4", s_pc4, 32'h404);

    // Redirect in the same cycle as a response (L=1).
    lat_fixed = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_pend && mem_due == cyc) found = 1'b1;
      else cycle();
    end
    chk("t4_sync", {31'b0, found}, 32'd1);
    br = 1'b1; bt = 32'h200;
    cycle();
    br = 1'b0;
    chk("t4_redir_noreq", {31'b0, s_req}, 32'd0);
    cycle();
    chk("t4_req_next", {31'b0, s_req}, 32'd1);
    chk("t4_req_addr", s_addr, 32'h200);
    chk("t4_not_pushed", {31'b0, s_valid}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (s_valid) found = 1'b1;
    end
    chk("t4_head_pc", s_pc, 32'h200);

    // PC wrap at the top of the address space.
    jp = 1'b1; jt = 32'hFFFF_FFFC;
    cycle();
    jp = 1'b0;
    nreq = 0; seen = 1'b0;
    ra[0] = 32'hDEAD_BEEF; ra[1] = 32'hDEAD_BEEF;
    for (int i = 0; i < 20 && (nreq < 2 || !seen); i++) begin
      cycle();
      if (s_req && nreq < 2) begin ra[nreq] = s_addr; nreq++; end
      if (s_valid && !seen) begin seen = 1'b1; fpc = s_pc; fpc4 = s_pc4; end
    end
    chk("t5_req0", ra[0], 32'hFFFF_FFFC);
    chk("t5_req1", ra[1], 32'h0000_0000);
    chk("t5_head_pc", fpc, 32'hFFFF_FFFC);
    chk("t5_head_pc4", fpc4, 32'h0000_0000);

    // Randomized traffic with variable latency and spurious strobes.
    lat_fixed = 0; spur_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      reset  = !(i >= 500 && i < 502);
      hazard = ($urandom_range(0, 9) < 3);
      k      = $urandom_range(0, 99);
      jp     = (k < 3) || (k == 99);
      br     = (k >= 3 && k < 7) || (k == 99);
      jt     = $urandom() & 32'hFFFF_FFFC;
      bt     = $urandom() & 32'hFFFF_FFFC;
      cycle();
    end
    reset = 1'b1; hazard = 1'b0; jp = 1'b0; br = 1'b0; spur_en = 1'b0;
    repeat (6) cycle();

`ifdef FETCH_PERF_COUNTERS_EN
    reset = 1'b0;
    repeat (2) cycle();
    chk("pc_rst_stall", s_stall, 32'd0);
    chk("pc_rst_redir", s_redir, 32'd0);
    reset = 1'b1; lat_fixed = 1; hazard = 1'b1; nv = 0;
    for (int i = 0; i < 30 && nv < 5; i++) begin
      cycle();
      if (s_valid) nv++;
    end
    hazard = 1'b0;
    jp = 1'b1; jt = 32'h300;
    cycle();
    jp = 1'b0; br = 1'b1; bt = 32'h500;
    cycle();
    br = 1'b0;
    cycle();
    chk("pc_stall5", s_stall, 32'd5);
    chk("pc_redir2", s_redir, 32'd2);
    reset = 1'b0;
    repeat (2) cycle();
    chk("pc_rst2_stall", s_stall, 32'd0);
    chk("pc_rst2_redir", s_redir, 32'd0);
    reset = 1'b1;
    cycle();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue_stage.md
# fetch_queue_stage

Parametrised instruction-fetch stage with a decoupling buffer between instruction memory and decode. Generates the PC sequence, issues single-outstanding requests to a variable-latency instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry queue. Decode pops the queue under a hazard stall. Branch/jump redirects flush the queue and squash the in-flight response.

## Interface
- ADDR_WIDTH, 32: PC and memory address width.
- DATA_WIDTH, 32: instruction width; PC_STEP = DATA_WIDTH/8.
- DEPTH, 4: queue entries, power of two, ≥ 2.
- RESET_PC, 0: PC loaded at reset.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- hazard  input  1  decode stall; no pop while high.
- outputBrachControlInput  input  1  take branch.
- pcBranchInput  input  ADDR_WIDTH  branch target.
- jumpInput  input  1  take jump; has priority over branch.
- pcJumpInput  input  ADDR_WIDTH  jump target.
- imemReq  output  1  request strobe, one cycle per request.
- imemAddr  output  ADDR_WIDTH  request address, valid with imemReq.
- imemValid  input  1  response strobe, in order.
- imemData  input  DATA_WIDTH  response instruction.
- validOutput  output  1  queue head valid.
- instructionOutput  output  DATA_WIDTH  head instruction.
- pcOutput  output  ADDR_WIDTH  head PC.
- pc4Output  output  ADDR_WIDTH  head PC + PC_STEP, modulo 2^ADDR_WIDTH.

## Operation
- Reset (reset low at edge): fetchPc ← RESET_PC, queue empty, outstanding ← 0, drop ← 0. Outputs: imemReq 0, validOutput 0, instructionOutput/pcOutput/pc4Output 0.
- Pop = validOutput & !hazard & !redirect.
- Redirect = jumpInput | outputBrachControlInput. Target = jump ? pcJumpInput : pcBranchInput.
- Issue condition: !redirect & (!outstanding | imemValid) & (count + outstanding_after_response < DEPTH). On issue, imemReq=1 and imemAddr=fetchPc; the registered fetchPc advances by PC_STEP and wraps modulo 2^ADDR_WIDTH.
- Response: imemValid while outstanding & !drop & !redirect pushes {imemData, PC of request}. imemValid with no outstanding request is ignored.
- Redirect cycle:
  - queue cleared; fetchPc ← target; no request issued;
  - an outstanding request sets drop, or drop stays clear if its response arrives that same cycle, which is discarded.
- Drop: the next imemValid clears drop and outstanding without pushing.
- Push and pop in the same cycle: count unchanged. Reservation (count + outstanding ≤ DEPTH) guarantees push never hits a full queue.
- Redirect with pop and push in the same cycle: flush wins; count ← 0.

## Timing
- Redirect at cycle t: target request at t+1 if nothing is outstanding. Otherwise the request goes out in the cycle the dropped response returns.
- Memory latency L ≥ 1 cycles: first instruction visible at validOutput L+1 cycles after its request (one cycle for the queue write).
- Head outputs are combinational from queue storage. No extra latency on pop.
- Steady-state throughput: one instruction per L cycles (single outstanding).

## Configuration
- FETCH_PERF_COUNTERS_EN defined: adds outputs stallCount and redirectCount (32-bit, saturating, reset 0).
  - stallCount increments on cycles with validOutput & hazard.
  - redirectCount increments on each redirect cycle.
- Undefined: ports and logic absent; behaviour otherwise identical.

## Structure
- Package fetch_pkg holds:
  - default constants: ADDR_WIDTH, DATA_WIDTH, RESET_PC;
  - a PC_STEP helper function;
  - the fetch_entry_t typedef {instr, pc} for the 32-bit configuration.
- Sub-module fetch_fifo:
  - synchronous FIFO of {instr, pc} with push, pop, flush, count;
  - wrap-around read/write pointers, log2(DEPTH)+1 count.
- Top holds PC register, outstanding/drop flags, issue logic, and optional counters.

## Test plan
- Reset with RESET_PC=0x100, L=1, hazard=0 → requests 0x100, 0x104, 0x108 on consecutive issues. The first validOutput has pcOutput=0x100 and pc4Output=0x104.
- hazard held high, L=1, DEPTH=4 → exactly four entries buffered and imemReq stays 0. Release hazard → entries pop in PC order and issue resumes.
- Jump to 0x400 and branch to 0x200 in the same cycle, with L=3 and a request in flight → that response is discarded, the queue empties, and the next request and head PC are 0x400.
- Redirect asserted in the same cycle as imemValid → data not pushed; the next request targets the redirect address at t+1.
- fetchPc=0xFFFFFFFC → next request 0x00000000 and pc4Output=0x00000000.
- With FETCH_PERF_COUNTERS_EN, 5 stalled-valid cycles and 2 redirects → stallCount=5, redirectCount=2. Reset returns both to 0.
